// File: rtl/maze_nav_ctrl_pkg.sv
// Shared definitions for the maze game-logic stage: bomb FSM state codes,
// direction encoding, navigator FSM states, grid cell type and wall lookup.
// Combinational helpers only; no latency, no flow control.
package maze_nav_ctrl_pkg;

   // Top-level bomb FSM state codes, shared with the display stage.
   localparam logic [2:0] BOMB_IDLE      = 3'b000;
   localparam logic [2:0] BOMB_ARMED     = 3'b001;
   localparam logic [2:0] BOMB_ACTIVATED = 3'b010;
   localparam logic [2:0] BOMB_DEFUSED   = 3'b011;
   localparam logic [2:0] BOMB_EXPLODED  = 3'b100;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} nav_state_t;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
   } cell_t;

   // True when leaving cell c in direction d hits a wall or the grid edge.
   // h_wall[y*8+x] sits below (x,y); v_wall[y*7+x] sits right of (x,y).
   function automatic logic wall_blocked(input cell_t c, input dir_t d,
                                         input logic [55:0] h_wall,
                                         input logic [55:0] v_wall);
      logic [5:0] hi_up;
      logic [5:0] hi_dn;
      logic [5:0] vi;
      logic       blk;
      hi_up = {c.y - 3'd1, c.x};
      hi_dn = {c.y, c.x};
      vi    = {c.y, 3'b000} - {3'b000, c.y} + {3'b000, c.x};
      blk   = 1'b1;
      case (d)
         DIR_UP:    blk = (c.y == 3'd0) || h_wall[hi_up];
         DIR_DOWN:  blk = (c.y == 3'd7) || h_wall[hi_dn];
         DIR_LEFT:  blk = (c.x == 3'd0) || v_wall[vi - 6'd1];
         DIR_RIGHT: blk = (c.x == 3'd7) || v_wall[vi];
         default:   blk = 1'b1;
      endcase
      return blk;
   endfunction

endpackage

// File: rtl/maze_nav_ctrl_rom.sv
// Maze layout ROM: start cell, goal cell and wall maps for four hard-coded mazes.
// Latency: purely combinational.
// Backpressure: none.
// Ports: sel (layout index) -> start_x/start_y, goal_x/goal_y, h_wall[55:0], v_wall[55:0].
module maze_rom (
   input  logic [1:0]  sel,
   output logic [2:0]  start_x,
   output logic [2:0]  start_y,
   output logic [2:0]  goal_x,
   output logic [2:0]  goal_y,
   output logic [55:0] h_wall,
   output logic [55:0] v_wall
);

   always_comb begin
      start_x = 3'd0;
      start_y = 3'd0;
      goal_x  = 3'd0;
      goal_y  = 3'd0;
      h_wall  = '0;
      v_wall  = '0;
      case (sel)
         2'd0: begin
            start_x = 3'd1; start_y = 3'd1; goal_x = 3'd6; goal_y = 3'd6;
            v_wall[8]  = 1'b1;   // (1,1)|(2,1)
            h_wall[36] = 1'b1;   // (4,4)/(4,5)
         end
         2'd1: begin
            start_x = 3'd0; start_y = 3'd0; goal_x = 3'd7; goal_y = 3'd7;
            v_wall[0]  = 1'b1;   // (0,0)|(1,0)
            h_wall[19] = 1'b1;   // (3,2)/(3,3)
         end
         2'd2: begin
            start_x = 3'd7; start_y = 3'd0; goal_x = 3'd0; goal_y = 3'd7;
            v_wall[6]  = 1'b1;   // (6,0)|(7,0)
            h_wall[42] = 1'b1;   // (2,5)/(2,6)
         end
         default: begin
            start_x = 3'd3; start_y = 3'd3; goal_x = 3'd4; goal_y = 3'd4;
            v_wall[24] = 1'b1;   // (3,3)|(4,3)
            h_wall[27] = 1'b1;   // (3,3)/(3,4)
         end
      endcase
   end

endmodule

// File: rtl/maze_nav_ctrl.sv
// Maze game logic: debounces four buttons and walks the player over an 8x8 maze, counting wall bumps.
// Latency: raw press -> 2 sync + DEB_CYCLES stable samples -> position/strike update one edge later.
// Backpressure: none; presses outside PLAY are dropped.
// Ports: clk, rst (async, active-low), current_state, maze_sel, btn_up/down/left/right ->
//        cur_x/cur_y, final_x/final_y, strike (pulse), strikes, win, fail.
module maze_nav_ctrl
   import maze_nav_ctrl_pkg::*;
#(
   parameter int         DEB_CYCLES  = 1_000_000,
   parameter int         MAX_STRIKES = 3,
   parameter logic [2:0] ACTIVATED   = BOMB_ACTIVATED
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] current_state,
   input  logic [1:0] maze_sel,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [2:0] cur_x,
   output logic [2:0] cur_y,
   output logic [2:0] final_x,
   output logic [2:0] final_y,
   output logic       strike,
   output logic [2:0] strikes,
   output logic       win,
   output logic       fail
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [3:0] btn_raw;
   logic [3:0] press;

   assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

   // One debouncer per button; bit index matches the dir_t encoding.
   for (genvar i = 0; i < 4; i++) begin : g_deb
      logic [1:0]    sync;
      logic          stable;
      logic          stable_d;
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync     <= 2'b00;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
         end else begin
            sync     <= {sync[0], btn_raw[i]};
            stable_d <= stable;
            // Counter runs only while the synchronised level disagrees with the
            // accepted one; any agreeing sample restarts the qualification.
            if (sync[1] == stable) begin
               cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
               stable <= sync[1];
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

      assign press[i] = stable & ~stable_d;
   end

   nav_state_t state_q, state_d;
   logic [2:0] prev_cs;
   logic [1:0] sel_q, sel_d;
   cell_t      cur_q, cur_d, fin_q, fin_d, nxt;
   logic [2:0] strikes_q, strikes_d, strikes_inc;
   logic       win_q, win_d, fail_q, fail_d, strike_q, strike_d;

   logic [2:0]  rom_sx, rom_sy, rom_gx, rom_gy;
   logic [55:0] rom_h, rom_v;
   logic [1:0]  rom_sel;
   logic        entry, mv_vld, blocked;
   dir_t        dir;

   // During LOAD the ROM shows the incoming selection; afterwards the latched one,
   // so maze_sel changes mid-game cannot move the walls.
   assign rom_sel = (state_q == S_LOAD) ? maze_sel : sel_q;

   maze_rom u_rom (
      .sel     (rom_sel),
      .start_x (rom_sx),
      .start_y (rom_sy),
      .goal_x  (rom_gx),
      .goal_y  (rom_gy),
      .h_wall  (rom_h),
      .v_wall  (rom_v)
   );

   assign entry       = (current_state == ACTIVATED) && (prev_cs != ACTIVATED);
   assign mv_vld      = |press;
   assign strikes_inc = strikes_q + 3'd1;

   always_comb begin
      if (press[DIR_UP])        dir = DIR_UP;
      else if (press[DIR_DOWN]) dir = DIR_DOWN;
      else if (press[DIR_LEFT]) dir = DIR_LEFT;
      else                      dir = DIR_RIGHT;
   end

   always_comb begin
      nxt = cur_q;
      case (dir)
         DIR_UP:    nxt.y = cur_q.y - 3'd1;
         DIR_DOWN:  nxt.y = cur_q.y + 3'd1;
         DIR_LEFT:  nxt.x = cur_q.x - 3'd1;
         default:   nxt.x = cur_q.x + 3'd1;
      endcase
   end

   assign blocked = wall_blocked(cur_q, dir, rom_h, rom_v);

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cur_d     = cur_q;
      fin_d     = fin_q;
      strikes_d = strikes_q;
      win_d     = win_q;
      fail_d    = fail_q;
      strike_d  = 1'b0;
      if (current_state != ACTIVATED) begin
         state_d = S_IDLE;   // results stay visible to the display
      end else begin
         case (state_q)
            S_IDLE: begin
               if (entry) state_d = S_LOAD;
            end
            S_LOAD: begin
               sel_d     = maze_sel;
               cur_d     = '{x: rom_sx, y: rom_sy};
               fin_d     = '{x: rom_gx, y: rom_gy};
               strikes_d = 3'd0;
               win_d     = 1'b0;
               fail_d    = 1'b0;
               state_d   = S_PLAY;
            end
            S_PLAY: begin
               if (mv_vld) begin
                  if (blocked) begin
                     strike_d  = 1'b1;
                     strikes_d = strikes_inc;
                     if (strikes_inc == 3'(MAX_STRIKES)) begin
                        fail_d  = 1'b1;
                        state_d = S_DONE;
                     end
                  end else begin
                     cur_d = nxt;
                     if (nxt == fin_q) begin
                        win_d   = 1'b1;
                        state_d = S_DONE;
                     end
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         prev_cs   <= 3'b000;   // never ACTIVATED, so a held-active release counts as entry
         sel_q     <= 2'd0;
         cur_q     <= '0;
         fin_q     <= '0;
         strikes_q <= 3'd0;
         win_q     <= 1'b0;
         fail_q    <= 1'b0;
         strike_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_cs   <= current_state;
         sel_q     <= sel_d;
         cur_q     <= cur_d;
         fin_q     <= fin_d;
         strikes_q <= strikes_d;
         win_q     <= win_d;
         fail_q    <= fail_d;
         strike_q  <= strike_d;
      end
   end

   assign cur_x   = cur_q.x;
   assign cur_y   = cur_q.y;
   assign final_x = fin_q.x;
   assign final_y = fin_q.y;
   assign strike  = strike_q;
   assign strikes = strikes_q;
   assign win     = win_q;
   assign fail    = fail_q;

endmodule
